// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the execute stage and the RV64M
// multiply/divide engine.
interface muldiv_ctrl_if;
  logic        req_valid_i;
  logic        mul_en_i;
  logic [63:0] rs1_data_i;
  logic [63:0] rs2_data_i;
  logic        rs1_sign_i;
  logic        rs2_sign_i;
  logic        flush_i;
  logic        resp_ack_i;
  logic        resp_valid_o;
  logic [63:0] data_1_o;
  logic [63:0] data_2_o;
  logic        stall_o;
  logic        busy_o;

  modport master (
    output req_valid_i, mul_en_i,
    output rs1_data_i, rs2_data_i,
    output rs1_sign_i, rs2_sign_i,
    output flush_i, resp_ack_i,
    input  resp_valid_o, data_1_o,
    input  data_2_o, stall_o, busy_o
  );

  modport slave (
    input  req_valid_i, mul_en_i,
    input  rs1_data_i, rs2_data_i,
    input  rs1_sign_i, rs2_sign_i,
    input  flush_i, resp_ack_i,
    output resp_valid_o, data_1_o,
    output data_2_o, stall_o, busy_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV64M iterative multiply/divide engine, 1 bit per cycle.
// Optional MULDIV_FAST_SPECIAL_EN: div-by-zero / signed overflow skip CALC.
module muldiv_ctrl (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  state_e       state;
  logic [5:0]   cnt;
  logic         mul_q;
  logic         neg_res;
  logic         neg_rem;
  logic         dz;
  logic [127:0] opa;
  logic [63:0]  opb;
  logic [127:0] acc;
  logic         resp_valid;
  logic [63:0]  d1;
  logic [63:0]  d2;

  logic         neg1;
  logic         neg2;
  logic [63:0]  abs1;
  logic [63:0]  abs2;
  logic         zero_in;
  logic         fast_hit;
  logic [127:0] mul_nxt;
  logic [64:0]  rem_sh;
  logic         ge;
  logic [63:0]  rem_dif;
  logic [127:0] prod_neg;
  logic [63:0]  quo_fix;
  logic [63:0]  rem_fix;

  always_comb begin
    neg1    = bus.rs1_sign_i & bus.rs1_data_i[63];
    neg2    = bus.rs2_sign_i & bus.rs2_data_i[63];
    abs1    = neg1 ? 64'd0 - bus.rs1_data_i : bus.rs1_data_i;
    abs2    = neg2 ? 64'd0 - bus.rs2_data_i : bus.rs2_data_i;
    zero_in = (bus.rs2_data_i == 64'd0);
    fast_hit = 1'b0;
`ifdef MULDIV_FAST_SPECIAL_EN
    fast_hit = !bus.mul_en_i &&
      (zero_in ||
       (bus.rs1_sign_i && bus.rs2_sign_i &&
        bus.rs1_data_i == 64'h8000_0000_0000_0000 &&
        bus.rs2_data_i == 64'hFFFF_FFFF_FFFF_FFFF));
`endif
    mul_nxt  = opb[0] ? acc + opa : acc;
    rem_sh   = {acc[63:0], opa[63]};
    ge       = (rem_sh >= {1'b0, opb});
    rem_dif  = rem_sh[63:0] - opb;
    prod_neg = 128'd0 - acc;
    // Divide-by-zero quotient stays all ones; remainder keeps dividend sign
    quo_fix  = (neg_res && !dz) ? 64'd0 - opa[63:0] : opa[63:0];
    rem_fix  = neg_rem ? 64'd0 - acc[63:0] : acc[63:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      mul_q      <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      dz         <= 1'b0;
      opa        <= 128'd0;
      opb        <= 64'd0;
      acc        <= 128'd0;
      resp_valid <= 1'b0;
      d1         <= 64'd0;
      d2         <= 64'd0;
    end else if (bus.flush_i) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      resp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            mul_q   <= bus.mul_en_i;
            neg_res <= neg1 ^ neg2;
            neg_rem <= neg1;
            dz      <= zero_in;
            cnt     <= 6'd0;
            acc     <= 128'd0;
            opa     <= {64'd0, abs1};
            opb     <= abs2;
            if (fast_hit) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              d1 <= zero_in ? 64'hFFFF_FFFF_FFFF_FFFF
                            : 64'h8000_0000_0000_0000;
              d2 <= zero_in ? bus.rs1_data_i : 64'd0;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (mul_q) begin
            acc <= mul_nxt;
            opa <= opa << 1;
            opb <= opb >> 1;
          end else begin
            acc[63:0] <= ge ? rem_dif : rem_sh[63:0];
            opa[63:0] <= {opa[62:0], ge};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd63) state <= FIX;
        end
        FIX: begin
          if (mul_q) begin
            d1 <= neg_res ? prod_neg[63:0] : acc[63:0];
            d2 <= neg_res ? prod_neg[127:64] : acc[127:64];
          end else begin
            d1 <= quo_fix;
            d2 <= rem_fix;
          end
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (bus.resp_ack_i) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid_o = resp_valid;
  assign bus.data_1_o     = d1;
  assign bus.data_2_o     = d2;
  assign bus.busy_o       = (state != IDLE);
  assign bus.stall_o      = bus.req_valid_i && (state != DONE);

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller and iterative engine for the RV64M multiply/divide resource. Accepts one request at a time from the execute stage (operands, sign flags, mul/div select), runs a 1-bit-per-cycle shift-add multiply or restoring divide on operand magnitudes, and applies sign correction. Holds the results until the pipeline acknowledges them, and drives a stall while a request is outstanding. Word variants arrive already extended by the execute stage, and the execute stage selects and truncates the result.

## Interface
- No parameters; datapath width fixed at 64 bits.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid_i  in  1  execute stage presents a mul/div instruction
- mul_en_i  in  1  1 = multiply, 0 = divide/remainder
- rs1_data_i  in  64  multiplicand / dividend
- rs2_data_i  in  64  multiplier / divisor
- rs1_sign_i  in  1  1 = treat rs1 as signed
- rs2_sign_i  in  1  1 = treat rs2 as signed
- flush_i  in  1  pipeline flush; abort any operation
- resp_ack_i  in  1  pipeline consumes the held result this cycle
- resp_valid_o  out  1  results valid and held
- data_1_o  out  64  product[63:0] or quotient
- data_2_o  out  64  product[127:64] or remainder
- stall_o  out  1  hold execute stage and upstream
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, CALC, FIX, DONE. 6-bit iteration counter.
- IDLE: if req_valid_i && !flush_i, latch the absolute values of the operands and the negate flags, clear the accumulators and the counter, and go to CALC.
  - A signed operand is negative when its sign flag is set and its msb is 1. Its absolute value is the 64-bit two's-complement negation.
  - neg_res = neg1 ^ neg2 for the product and the quotient; neg_rem = neg1.
- CALC, multiply: 128-bit product accumulator. On each step, add the multiplicand shifted left by the counter if the current multiplier bit is 1.
- CALC, divide: restoring division over 64 steps, msb first. Shift the remainder left by 1 and bring in the next dividend bit. If remainder >= divisor, subtract the divisor and set the quotient bit.
- CALC advances to FIX once the counter reaches 63.
- FIX: mul negates the full 128-bit product if neg_res. div negates the quotient if neg_res and the remainder if neg_rem. Go to DONE.
- DONE: resp_valid_o = 1 and data outputs hold stable. On resp_ack_i go to IDLE on the next edge.
- Divide by zero (no fast path): yields quotient = all ones and remainder = dividend. Sign correction does not apply to this case, so the negation must be masked when divisor == 0.
- Signed overflow (-2^63 / -1): yields quotient 0x8000_0000_0000_0000 and remainder 0 through the normal arithmetic.
- stall_o = req_valid_i && !(state == DONE). The combinational path from req_valid_i is intentional.
- flush_i: from any state, go to IDLE on the next edge; resp_valid_o drops; the counter clears; there is no response for the flushed request.
- Simultaneous resp_ack_i and req_valid_i in DONE: acknowledge only. A new request is accepted no earlier than the following IDLE cycle.
- Operand inputs are ignored outside IDLE.

## Timing
- Reset: state IDLE, counter 0, resp_valid_o 0, data_1_o 0, data_2_o 0, busy_o 0, stall_o follows req_valid_i.
- Counting the accept cycle as 0: CALC occupies cycles 1-64, FIX cycle 65, DONE from cycle 66. Latency is 66 cycles to resp_valid_o.
- Throughput: one operation per 67 cycles minimum with an immediate acknowledge.
- The results are registered and change only on the FIX→DONE edge or on reset.

## Configuration
- MULDIV_FAST_SPECIAL_EN defined:
  - A divide with divisor == 0 goes IDLE→DONE with quotient all ones and remainder = dividend.
  - A signed -2^63 / -1 goes IDLE→DONE with quotient 0x8000_0000_0000_0000 and remainder 0.
  - resp_valid_o rises in cycle 1.
- Undefined: these cases take the full 66-cycle path and produce the same values.

## Test plan
- Signed mul 3 × -5 -> cycle 66: data_1_o = 0xFFFF_FFFF_FFFF_FFF1, data_2_o = 0xFFFF_FFFF_FFFF_FFFF; stall_o high during cycles 0-65.
- Unsigned mul 0xFFFF_FFFF_FFFF_FFFF × same -> data_1_o = 1, data_2_o = 0xFFFF_FFFF_FFFF_FFFE.
- Signed div -7 / 2 -> data_1_o = -3, data_2_o = -1.
- Unsigned div 7 / 0 -> data_1_o = all ones, data_2_o = 7. Arrives in cycle 1 with MULDIV_FAST_SPECIAL_EN, in cycle 66 without.
- Signed div 0x8000_0000_0000_0000 / -1 -> data_1_o = 0x8000_0000_0000_0000, data_2_o = 0.
- flush_i at cycle 20 of a multiply -> IDLE at cycle 21 with no resp_valid_o. A new 6 × 7 request then yields data_1_o = 42 after 66 cycles. Asserting rst mid-CALC clears all outputs immediately.
